// File: rtl/dds_pkg.sv
// Shared types and sizes for the DDS frequency control block.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding, key indices and BCD digit helpers.
package dds_pkg;

    localparam int NDIG  = 6;
    localparam int BCD_W = 24;
    localparam int FTW_W = 32;
    localparam int ACC_W = 20;

    // Bit positions of the keys in the packed key vectors, in priority order
    localparam int KE = 0;
    localparam int KU = 1;
    localparam int KD = 2;
    localparam int KL = 3;
    localparam int KR = 4;
    localparam int NKEY = 5;

    typedef enum logic [1:0] {
        CONV = 2'd0,
        LOAD = 2'd1,
        IDLE = 2'd2,
        EDIT = 2'd3
    } state_t;

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/dds_freq_ctrl_key_debounce.sv
// Key debouncer: 2-FF sync, stable counter, one-cycle press pulse on a debounced 1->0.
// Latency: 2 sync cycles + DB_CYCLES stable samples before level/press change.
// Backpressure: none; press is a fire-and-forget pulse.
module key_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES) + 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          differs;
    logic          accept;

    assign differs = (sync[1] != level);
    assign accept  = differs && (cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            press <= accept && !sync[1];
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dds_freq_ctrl.sv
// DDS front-panel control: debounced keys, 6-digit BCD editor, BCD->ftw conversion (AUTOREPEAT_EN adds ku/kd auto-repeat).
// Latency: ke accepted at T -> 6 CONV cycles -> ftw/ftw_valid registered at T+7.
// Backpressure: none; key events arriving in CONV/LOAD are dropped, ftw_valid is an unacknowledged pulse.
module dds_freq_ctrl
    import dds_pkg::*;
#(
    parameter int              DB_CYCLES = 1_000_000,
    parameter int              FTW_MUL   = 4467,
    parameter logic [BCD_W-1:0] FMAX_BCD  = 24'h100000,
    parameter logic [BCD_W-1:0] RESET_BCD = 24'h001000,
    parameter int              RPT_DLY   = 25_000_000,
    parameter int              RPT_PER   = 5_000_000
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             ke,
    input  logic             ku,
    input  logic             kd,
    input  logic             kl,
    input  logic             kr,
    output logic [BCD_W-1:0] disp_data,
    output logic [2:0]       cursor,
    output logic             editing,
    output logic [FTW_W-1:0] ftw,
    output logic             ftw_valid
);

    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] key_lvl;
    logic [NKEY-1:0] key_prs;
    logic [NKEY-1:0] key_rpt;
    logic [NKEY-1:0] ev_raw;

    assign key_raw = {kr, kl, kd, ku, ke};

    for (genvar g = 0; g < NKEY; g++) begin : g_db
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clkin(clkin),
            .rst_n(rst_n),
            .key  (key_raw[g]),
            .level(key_lvl[g]),
            .press(key_prs[g])
        );
    end

    state_t           state, nxt_state;
    logic [BCD_W-1:0] work, nxt_work;
    logic [BCD_W-1:0] committed, nxt_committed;
    logic [ACC_W-1:0] acc, nxt_acc;
    logic [2:0]       idx, nxt_idx;
    logic [2:0]       nxt_cursor;
    logic [FTW_W-1:0] nxt_ftw;
    logic             nxt_vld;

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RW      = $clog2(RPT_MAX) + 1;

    logic [RW-1:0] rpt_cnt;
    logic          rpt_first;
    logic          rpt_hold;
    logic          rpt_fire;

    // Repeat timing is measured from the most recent ku/kd press event
    assign rpt_hold = (state == EDIT) && !(key_lvl[KU] && key_lvl[KD]);
    assign rpt_fire = rpt_hold && !(key_prs[KU] || key_prs[KD]) &&
                      (rpt_first ? (rpt_cnt == RW'(RPT_DLY - 1))
                                 : (rpt_cnt == RW'(RPT_PER - 1)));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (!rpt_hold || key_prs[KU] || key_prs[KD]) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + RW'(1);
        end
    end

    assign key_rpt = {2'b00, rpt_fire & key_lvl[KU] & ~key_lvl[KD],
                      rpt_fire & ~key_lvl[KU], 1'b0};

    logic lvl_unused;
    assign lvl_unused = ^{key_lvl[KE], key_lvl[KL], key_lvl[KR]};
`else
    assign key_rpt = '0;

    logic lvl_unused;
    assign lvl_unused = ^{key_lvl, (RPT_DLY != RPT_PER)};
`endif

    assign ev_raw = key_prs | key_rpt;

    logic ev_e, ev_u, ev_d, ev_l, ev_r;
    assign ev_e = ev_raw[KE];
    assign ev_u = ev_raw[KU] & ~ev_raw[KE];
    assign ev_d = ev_raw[KD] & ~|ev_raw[KU:KE];
    assign ev_l = ev_raw[KL] & ~|ev_raw[KD:KE];
    assign ev_r = ev_raw[KR] & ~|ev_raw[KL:KE];

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CONV;
            work      <= RESET_BCD;
            committed <= RESET_BCD;
            acc       <= '0;
            idx       <= 3'd5;
            cursor    <= 3'd0;
            ftw       <= '0;
            ftw_valid <= 1'b0;
        end else begin
            state     <= nxt_state;
            work      <= nxt_work;
            committed <= nxt_committed;
            acc       <= nxt_acc;
            idx       <= nxt_idx;
            cursor    <= nxt_cursor;
            ftw       <= nxt_ftw;
            ftw_valid <= nxt_vld;
        end
    end

    logic [3:0] conv_dig;
    logic [3:0] cur_dig;
    assign conv_dig = work[{idx, 2'b00} +: 4];
    assign cur_dig  = work[{cursor, 2'b00} +: 4];

    always_comb begin
        nxt_state     = state;
        nxt_work      = work;
        nxt_committed = committed;
        nxt_acc       = acc;
        nxt_idx       = idx;
        nxt_cursor    = cursor;
        nxt_ftw       = ftw;
        nxt_vld       = 1'b0;
        case (state)
            CONV: begin
                // MSD first, so acc ends as the binary value of the BCD word
                nxt_acc = acc * ACC_W'(10) + ACC_W'(conv_dig);
                if (idx == 3'd0) nxt_state = LOAD;
                else             nxt_idx   = idx - 3'd1;
            end
            LOAD: begin
                nxt_ftw       = FTW_W'(acc) * FTW_W'(FTW_MUL);
                nxt_committed = work;
                nxt_vld       = 1'b1;
                nxt_state     = IDLE;
            end
            IDLE: begin
                if (ev_e) begin
                    nxt_state  = EDIT;
                    nxt_work   = committed;
                    nxt_cursor = 3'd0;
                end
            end
            EDIT: begin
                if (ev_e) begin
                    if (work > FMAX_BCD) nxt_work = FMAX_BCD;
                    nxt_state = CONV;
                    nxt_acc   = '0;
                    nxt_idx   = 3'd5;
                end else if (ev_u) begin
                    nxt_work[{cursor, 2'b00} +: 4] = bcd_inc(cur_dig);
                end else if (ev_d) begin
                    nxt_work[{cursor, 2'b00} +: 4] = bcd_dec(cur_dig);
                end else if (ev_l) begin
                    nxt_cursor = (cursor >= 3'd5) ? 3'd0 : cursor + 3'd1;
                end else if (ev_r) begin
                    nxt_cursor = (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
                end
            end
            default: nxt_state = CONV;
        endcase
    end

    assign editing   = (state == EDIT);
    assign disp_data = editing ? work : committed;

endmodule

// File: tb/tb_dds_freq_ctrl.sv
// Directed bench for dds_freq_ctrl with short debounce/repeat timing.
module tb_dds_freq_ctrl;

    logic        clkin = 1'b0;
    logic        rst_n = 1'b0;
    logic        ke = 1'b1, ku = 1'b1, kd = 1'b1, kl = 1'b1, kr = 1'b1;
    logic [23:0] disp_data;
    logic [2:0]  cursor;
    logic        editing;
    logic [31:0] ftw;
    logic        ftw_valid;

    localparam logic [4:0] M_E = 5'b00001;
    localparam logic [4:0] M_U = 5'b00010;
    localparam logic [4:0] M_D = 5'b00100;
    localparam logic [4:0] M_L = 5'b01000;
    localparam logic [4:0] M_R = 5'b10000;

    int n_cmp = 0;
    int n_bad = 0;

    dds_freq_ctrl #(
        .DB_CYCLES(4),
        .RPT_DLY  (20),
        .RPT_PER  (8)
    ) dut (
        .clkin    (clkin),
        .rst_n    (rst_n),
        .ke       (ke),
        .ku       (ku),
        .kd       (kd),
        .kl       (kl),
        .kr       (kr),
        .disp_data(disp_data),
        .cursor   (cursor),
        .editing  (editing),
        .ftw      (ftw),
        .ftw_valid(ftw_valid)
    );

    always #5 clkin = ~clkin;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
        end
    endtask

    task automatic drive(input logic [4:0] m);
        {kr, kl, kd, ku, ke} = ~m;
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clkin);
        drive(m);
        repeat (12) @(negedge clkin);
        drive(5'b0);
        repeat (12) @(negedge clkin);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_ftw"}, ftw, 32'd0);
        check_val({tag, "_vld"}, {31'd0, ftw_valid}, 32'd0);
        check_val({tag, "_cur"}, {29'd0, cursor}, 32'd0);
        check_val({tag, "_edit"}, {31'd0, editing}, 32'd0);
        check_val({tag, "_disp"}, {8'd0, disp_data}, 32'h001000);
    endtask

    // Release reset and expect ftw_valid on the 7th rising edge
    task automatic boot(input string tag);
        int lat;
        lat = 0;
        @(negedge clkin);
        rst_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clkin);
            #1;
            if (ftw_valid) begin
                lat = i;
                break;
            end
        end
        check_val({tag, "_lat"}, lat, 7);
        check_val({tag, "_ftw"}, ftw, 32'd4_467_000);
        @(negedge clkin);
        check_val({tag, "_disp"}, {8'd0, disp_data}, 32'h001000);
        check_val({tag, "_edit"}, {31'd0, editing}, 32'd0);
    endtask

    // Press ke in EDIT; ftw_valid must follow 7 edges after EDIT is left
    task automatic commit(input string tag, input logic [31:0] exp_ftw, input logic [23:0] exp_disp);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clkin);
        drive(M_E);
        for (int i = 0; i < 30; i++) begin
            @(posedge clkin);
            #1;
            if (!editing) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_leave"}, {31'd0, seen}, 32'd1);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clkin);
            #1;
            if (ftw_valid) begin
                lat = i;
                break;
            end
        end
        check_val({tag, "_lat"}, lat, 7);
        check_val({tag, "_ftw"}, ftw, exp_ftw);
        @(posedge clkin);
        #1;
        check_val({tag, "_pulse"}, {31'd0, ftw_valid}, 32'd0);
        @(negedge clkin);
        drive(5'b0);
        repeat (12) @(negedge clkin);
        check_val({tag, "_disp"}, {8'd0, disp_data}, {8'd0, exp_disp});
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit changed;
        logic [23:0] rpt_exp;

        // 1: reset state and boot conversion
        repeat (3) @(negedge clkin);
        check_reset_vals("rst");
        boot("boot");

        // 2: edit sequence
        press(M_E);
        check_val("edit_enter", {31'd0, editing}, 32'd1);
        check_val("edit_cur0", {29'd0, cursor}, 32'd0);
        repeat (3) press(M_L);
        check_val("edit_cur3", {29'd0, cursor}, 32'd3);
        repeat (2) press(M_U);
        check_val("edit_up2", {8'd0, disp_data}, 32'h003000);
        commit("commit3k", 32'd13_401_000, 24'h003000);

        // 3: wraps
        press(M_E);
        press(M_D);
        check_val("wrap_dec", {8'd0, disp_data}, 32'h003009);
        press(M_R);
        check_val("wrap_right", {29'd0, cursor}, 32'd5);
        press(M_L);
        check_val("wrap_left", {29'd0, cursor}, 32'd0);
        press(M_U);
        check_val("wrap_inc", {8'd0, disp_data}, 32'h003000);

        // 4: clamp 999999 -> 100000
        press(M_D);
        repeat (2) begin
            press(M_L);
            press(M_D);
        end
        press(M_L);
        repeat (4) press(M_D);
        repeat (2) begin
            press(M_L);
            press(M_D);
        end
        check_val("clamp_pre", {8'd0, disp_data}, 32'h999999);
        commit("clamp", 32'd446_700_000, 24'h100000);

        // 5a: two-cycle glitch on ku is filtered
        press(M_E);
        @(negedge clkin);
        drive(M_U);
        repeat (2) @(negedge clkin);
        drive(5'b0);
        repeat (20) @(negedge clkin);
        check_val("bounce", {8'd0, disp_data}, 32'h100000);

        // 5b: ku + kl together, ku wins
        press(M_U | M_L);
        check_val("prio_disp", {8'd0, disp_data}, 32'h100001);
        check_val("prio_cur", {29'd0, cursor}, 32'd0);

        // 5c: reset mid-edit
        @(negedge clkin);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        boot("reboot");

        // 6: held ku
        press(M_E);
        @(negedge clkin);
        drive(M_U);
        changed = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clkin);
            if (disp_data[3:0] != 4'd0) begin
                changed = 1'b1;
                break;
            end
        end
        check_val("hold_first", {31'd0, changed}, 32'd1);
        repeat (40) @(negedge clkin);
        drive(5'b0);
        repeat (20) @(negedge clkin);
`ifdef AUTOREPEAT_EN
        rpt_exp = 24'h001005;
`else
        rpt_exp = 24'h001001;
`endif
        check_val("hold_count", {8'd0, disp_data}, {8'd0, rpt_exp});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
